ysyx_24100006_pc_unit: RTL and testbench
========================================

// Module: ysyx_24100006_pc_unit
// PURPOSE
//  Parametrised successor to the combinational next-PC logic. Owns the architectural PC register
//  and issues fetch requests to the IFU over a valid/ready handshake. Resolves the next PC when
//  the EXU reports execution: full RV32 branch set, JAL/JALR, trap entry, mret, and target-misalign
//  detection. Runs one instruction at a time (multicycle core): REQ -> fetch in flight -> resolve.
// PARAMETERS
//  XLEN      32             datapath / PC width
//  RESET_PC  32'h8000_0000  PC loaded on reset
//  CNT_W     32             width of the retired-instruction counter
// PORTS
//  clock          in   1     core clock
//  reset          in   1     asynchronous, active-high reset
//  out_valid      out  1     fetch request valid
//  out_ready      in   1     IFU accepts out_pc
//  out_pc         out  XLEN  fetch address; stable while out_valid && !out_ready
//  exe_valid      in   1     EXU resolved the current instruction (1-cycle pulse)
//  skip_mode      in   4     0 NJUMP, 1 JAL, 2 JALR, 3 BRANCH; 4..15 treated as NJUMP
//  br_funct3      in   3     branch condition (funct3 encoding)
//  rs1_data       in   XLEN  rs1 operand (compare source and JALR base)
//  rs2_data       in   XLEN  rs2 operand (compare source)
//  sext_imm       in   XLEN  sign-extended immediate
//  trap_valid     in   1     ecall/exception on this instruction; qualified by exe_valid
//  mret_valid     in   1     mret on this instruction; qualified by exe_valid
//  mtvec          in   XLEN  trap vector; bits [1:0] forced to 0
//  mepc           in   XLEN  return address for mret
//  misalign_valid out  1     1-cycle pulse: taken target not 4-byte aligned
//  misalign_addr  out  XLEN  offending target; held until the next pulse
//  retire_cnt     out  CNT_W count of exe_valid events accepted in WAIT
// BEHAVIOUR
//  Reset: state=IDLE, out_pc=RESET_PC, out_valid=0, misalign_valid=0, misalign_addr=0, retire_cnt=0.
//  FSM: IDLE -> REQ unconditionally, one cycle after reset deasserts.
//   REQ:  out_valid=1. On out_valid && out_ready -> WAIT. exe_valid in REQ is ignored.
//   WAIT: out_valid=0. On exe_valid, load out_pc with the resolved next PC,
//         increment retire_cnt, -> REQ. exe_valid is therefore accepted only in WAIT.
//  Next-PC priority (evaluated on exe_valid):
//   trap_valid -> mtvec & ~3; else mret_valid -> mepc; else jump/branch; else pc+4.
//  Targets:
//   JAL = pc+imm.
//   JALR = (rs1+imm) & ~1.
//   BRANCH taken = pc+imm, not taken = pc+4.
//  Branch conditions:
//   funct3 000 EQ, 001 NE, 100 signed LT, 101 signed GE, 110 unsigned LT, 111 unsigned GE.
//   010/011 are never taken.
//  Arithmetic is modulo 2^XLEN; pc+4 at 32'hFFFF_FFFC wraps to 0. No carries are kept.
//  Misalign: applies only when a JAL/JALR/taken-branch target has target[1:0] != 0.
//   Then out_pc = mtvec & ~3, misalign_valid=1 for exactly 1 cycle, misalign_addr=target.
//   Traps and mret are never misalign-checked.
//  retire_cnt wraps at 2^CNT_W to 0.
//  Reset mid-operation (any state): immediate return to the reset values, no pending event kept.
//  Latency: redirect visible on out_pc and out_valid=1 in the cycle after the exe_valid edge.
// TESTING
//  Reset -> out_valid=0 first cycle, then 1 with out_pc=0x8000_0000; retire_cnt=0.
//  PC 0x8000_0000, BEQ rs1=rs2=5, imm=0x10 -> out_pc 0x8000_0010.
//   Same with BNE -> 0x8000_0004.
//  BLT rs1=0xFFFF_FFFF, rs2=1 -> taken; BLTU same operands -> not taken (pc+4).
//  JALR rs1=0x8000_0101, imm=0 -> 0x8000_0100, no misalign.
//   JAL imm=2 -> misalign pulse, addr 0x8000_0002, out_pc=mtvec.
//  exe_valid with trap_valid=1, mret_valid=1 and a taken branch -> out_pc=mtvec&~3.
//   PC 0xFFFF_FFFC with NJUMP -> out_pc 0x0.
//  Hold out_ready=0 for 5 cycles: out_pc stable and exe_valid in REQ ignored.
//   Assert reset during WAIT -> out_pc=RESET_PC, retire_cnt=0.

Source files
------------

// File: rtl/ysyx_24100006_pc_unit.sv
// PC owner for a multicycle RV32 core: issues one fetch per instruction over valid/ready, then resolves the next PC on exe_valid.
// Redirect appears on out_pc with out_valid=1 one cycle after exe_valid; out_pc holds steady while out_ready is low.
module ysyx_24100006_pc_unit #(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = 32'h8000_0000,
  parameter int                CNT_W    = 32
) (
  input  logic              clock,
  input  logic              reset,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  input  logic              exe_valid,
  input  logic [3:0]        skip_mode,
  input  logic [2:0]        br_funct3,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [XLEN-1:0]   sext_imm,
  input  logic              trap_valid,
  input  logic              mret_valid,
  input  logic [XLEN-1:0]   mtvec,
  input  logic [XLEN-1:0]   mepc,
  output logic              misalign_valid,
  output logic [XLEN-1:0]   misalign_addr,
  output logic [CNT_W-1:0]  retire_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  localparam logic [XLEN-1:0]  PC_STEP = XLEN'(4);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t state;
  state_t state_next;
  logic   accept;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_rel;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] trap_vec;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_next;
  logic            br_taken;
  logic            jump;
  logic            target_bad;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    out_valid  = 1'b0;
    accept     = 1'b0;
    case (state)
      S_IDLE: state_next = S_REQ;
      S_REQ: begin
        out_valid = 1'b1;
        if (out_ready) state_next = S_WAIT;
      end
      S_WAIT: begin
        accept = exe_valid;
        if (exe_valid) state_next = S_REQ;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    pc_plus4 = out_pc + PC_STEP;
    pc_rel   = out_pc + sext_imm;
    jalr_sum = rs1_data + sext_imm;
    trap_vec = {mtvec[XLEN-1:2], 2'b00};

    br_taken = 1'b0;
    case (br_funct3)
      3'b000:  br_taken = (rs1_data == rs2_data);
      3'b001:  br_taken = (rs1_data != rs2_data);
      3'b100:  br_taken = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101:  br_taken = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  br_taken = (rs1_data <  rs2_data);
      3'b111:  br_taken = (rs1_data >= rs2_data);
      default: br_taken = 1'b0;
    endcase

    jump   = 1'b0;
    target = pc_rel;
    case (skip_mode)
      4'd1: jump = 1'b1;
      4'd2: begin
        jump   = 1'b1;
        target = {jalr_sum[XLEN-1:1], 1'b0};
      end
      4'd3:    jump = br_taken;
      default: jump = 1'b0;
    endcase

    // Traps and mret bypass the alignment check entirely.
    target_bad = 1'b0;
    pc_next    = pc_plus4;
    if (trap_valid) begin
      pc_next = trap_vec;
    end else if (mret_valid) begin
      pc_next = mepc;
    end else if (jump) begin
      target_bad = (target[1:0] != 2'b00);
      pc_next    = target_bad ? trap_vec : target;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_pc         <= RESET_PC;
      misalign_valid <= 1'b0;
      misalign_addr  <= '0;
      retire_cnt     <= '0;
    end else begin
      misalign_valid <= 1'b0;
      if (accept) begin
        out_pc         <= pc_next;
        retire_cnt     <= retire_cnt + CNT_ONE;
        misalign_valid <= target_bad;
        if (target_bad) misalign_addr <= target;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24100006_pc_unit.sv
// Scoreboarded bench for ysyx_24100006_pc_unit: driver pushes model-predicted next PCs, monitor checks each new fetch request.
module tb_ysyx_24100006_pc_unit;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic        exe_valid = 1'b0;
  logic [3:0]  skip_mode = 4'd0;
  logic [2:0]  br_funct3 = 3'd0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic [31:0] sext_imm = '0;
  logic        trap_valid = 1'b0;
  logic        mret_valid = 1'b0;
  logic [31:0] mtvec = 32'h2000_0103;
  logic [31:0] mepc = 32'h8000_0400;
  logic        misalign_valid;
  logic [31:0] misalign_addr;
  logic [31:0] retire_cnt;

  ysyx_24100006_pc_unit dut (
    .clock(clock), .reset(reset),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .exe_valid(exe_valid), .skip_mode(skip_mode), .br_funct3(br_funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .sext_imm(sext_imm),
    .trap_valid(trap_valid), .mret_valid(mret_valid),
    .mtvec(mtvec), .mepc(mepc),
    .misalign_valid(misalign_valid), .misalign_addr(misalign_addr),
    .retire_cnt(retire_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    bit          mis;
    logic [31:0] addr;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          passes = 0;
  logic [31:0] m_pc  = RST_PC;
  logic [31:0] m_cnt = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, req, $time);
  endtask

  // Reference: straight from the ISA rules, one instruction at a time.
  function automatic exp_t model(input logic [31:0] pc, input int mode, input int f3,
                                 input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                                 input bit trap, input bit mret, input logic [31:0] tvec,
                                 input logic [31:0] ret_pc, input logic [31:0] cnt);
    exp_t e;
    bit taken;
    bit is_jump;
    logic [31:0] tgt;
    taken = 0;
    if (f3 == 0) taken = (a == b);
    if (f3 == 1) taken = (a != b);
    if (f3 == 4) taken = (int'(a) <  int'(b));
    if (f3 == 5) taken = (int'(a) >= int'(b));
    if (f3 == 6) taken = (a <  b);
    if (f3 == 7) taken = (a >= b);
    is_jump = (mode == 1) || (mode == 2) || (mode == 3 && taken);
    tgt = (mode == 2) ? ((a + imm) & 32'hFFFF_FFFE) : (pc + imm);
    e.mis  = 0;
    e.addr = '0;
    e.cnt  = cnt + 1;
    if (trap)         e.pc = tvec & 32'hFFFF_FFFC;
    else if (mret)    e.pc = ret_pc;
    else if (is_jump) begin
      if (tgt % 4 != 0) begin
        e.pc = tvec & 32'hFFFF_FFFC;
        e.mis = 1;
        e.addr = tgt;
      end else e.pc = tgt;
    end else e.pc = pc + 4;
    return e;
  endfunction

  task automatic push_reset_exp();
    exp_t e;
    e.pc = RST_PC; e.mis = 0; e.addr = '0; e.cnt = '0;
    sb.push_back(e);
  endtask

  // Monitor: every rising out_valid is a new fetch request to be scored.
  initial begin
    bit prev = 0;
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) prev = 0;
      else begin
        if (out_valid && !prev) begin
          if (sb.size() == 0) chk("unexpected_req", 32'd1, 32'd0);
          else begin
            e = sb.pop_front();
            chk("out_pc", out_pc, e.pc);
            chk("misalign_valid", 32'(misalign_valid), 32'(e.mis));
            if (e.mis) chk("misalign_addr", misalign_addr, e.addr);
            chk("retire_cnt", retire_cnt, e.cnt);
          end
        end else if (misalign_valid) chk("misalign_stray", 32'd1, 32'd0);
        prev = out_valid;
      end
    end
  end

  task automatic do_txn(input int mode, input int f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input bit trap, input bit mret,
                        input int stall, input bit rst_in_wait);
    bit   seen = 0;
    exp_t e;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clock);
      seen = out_valid;
    end
    if (!seen) begin
      chk("req_timeout", 32'd0, 32'd1);
      return;
    end
    for (int i = 0; i < stall; i++) begin
      out_ready = 1'b0;
      exe_valid = (i == 0);
      skip_mode = 4'd1; sext_imm = 32'h40; trap_valid = 1'b0; mret_valid = 1'b0;
      @(negedge clock);
      exe_valid = 1'b0;
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_pc", out_pc, m_pc);
      chk("stall_cnt", retire_cnt, m_cnt);
    end
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    chk("wait_valid", 32'(out_valid), 32'd0);
    repeat ($urandom_range(0, 2)) @(negedge clock);
    if (rst_in_wait) begin
      reset = 1'b1;
      #1;
      chk("rst_pc", out_pc, RST_PC);
      chk("rst_cnt", retire_cnt, 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      sb.delete();
      m_pc = RST_PC; m_cnt = '0;
      push_reset_exp();
      @(negedge clock);
      reset = 1'b0;
      return;
    end
    skip_mode = 4'(mode); br_funct3 = 3'(f3);
    rs1_data = a; rs2_data = b; sext_imm = imm;
    trap_valid = trap; mret_valid = mret;
    e = model(m_pc, mode, f3, a, b, imm, trap, mret, mtvec, mepc, m_cnt);
    sb.push_back(e);
    m_pc = e.pc; m_cnt = e.cnt;
    exe_valid = 1'b1;
    @(negedge clock);
    exe_valid = 1'b0;
    trap_valid = 1'b0; mret_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic [31:0] a;
    logic [31:0] imm;
    int mode;
    push_reset_exp();
    repeat (3) @(negedge clock);
    chk("reset_pc", out_pc, RST_PC);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_cnt", retire_cnt, 32'd0);
    chk("reset_mis", 32'(misalign_valid), 32'd0);
    chk("reset_mis_addr", misalign_addr, 32'd0);
    reset = 1'b0;
    #1;
    chk("idle_valid", 32'(out_valid), 32'd0);

    do_txn(3, 0, 32'd5, 32'd5, 32'h10, 0, 0, 5, 0);
    do_txn(3, 1, 32'd5, 32'd5, 32'h10, 0, 0, 0, 0);
    do_txn(3, 4, 32'hFFFF_FFFF, 32'd1, 32'h20, 0, 0, 1, 0);
    do_txn(3, 6, 32'hFFFF_FFFF, 32'd1, 32'h20, 0, 0, 0, 0);
    do_txn(2, 0, 32'h8000_0101, 32'd0, 32'd0, 0, 0, 0, 0);
    do_txn(1, 0, 32'd0, 32'd0, 32'd2, 0, 0, 0, 0);
    do_txn(3, 0, 32'd7, 32'd7, 32'h8, 1, 1, 0, 0);
    do_txn(0, 0, 32'd0, 32'd0, 32'd0, 0, 1, 0, 0);
    do_txn(2, 0, 32'hFFFF_FFFC, 32'd0, 32'd0, 0, 0, 0, 0);
    do_txn(0, 0, 32'd0, 32'd0, 32'd0, 0, 0, 0, 0);
    do_txn(3, 2, 32'd3, 32'd3, 32'h40, 0, 0, 0, 0);
    do_txn(3, 3, 32'd3, 32'd3, 32'h40, 0, 0, 0, 0);
    do_txn(9, 0, 32'd0, 32'd0, 32'h40, 0, 0, 0, 0);
    do_txn(2, 0, 32'h1000_0000, 32'd0, 32'h6, 0, 0, 0, 0);
    do_txn(0, 0, 32'd0, 32'd0, 32'd0, 0, 0, 2, 1);
    do_txn(1, 0, 32'd0, 32'd0, 32'h100, 0, 0, 0, 0);

    for (int n = 0; n < 150; n++) begin
      mtvec = $urandom;
      mepc  = $urandom;
      r     = $urandom;
      a     = $urandom;
      imm   = {{20{r[11]}}, r[11:0]};
      if (r[13:12] != 2'b00) imm[1:0] = 2'b00;
      mode  = (r[16:14] == 3'd7) ? int'($urandom_range(4, 15)) : int'(r[15:14]);
      do_txn(mode, int'(r[19:17]), a, r[20] ? a : $urandom, imm,
             (r[23:21] == 3'd0), (r[26:24] == 3'd0),
             int'($urandom_range(0, 2)), ($urandom_range(0, 39) == 0));
    end

    repeat (4) @(negedge clock);
    chk("queue_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
